// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small FIFO; frames go out back-to-back while bytes are queued.
// Latency: push at edge N drives the start bit from edge N+1; each frame lasts 10*CLKS_PER_BIT clocks.
// Backpressure: o_full reports a full FIFO; a push while full is dropped and flagged on o_overflow.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int DEPTH        = 4,
    parameter int DATA_BITS    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_wr,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_busy,
    output logic                 o_overflow,
    output logic                 o_tx
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [IW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic                 full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
    logic [DATA_BITS-1:0] mem_q [DEPTH];

    logic push, pop, baud_tc;

    assign push    = i_wr && !full_q;
    assign baud_tc = (baud_q == BAUD_LAST);

    // FSM next state; a byte leaves the FIFO only when a frame begins.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty_q) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                baud_d = baud_tc ? '0 : baud_q + BW'(1);
                if (baud_tc) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_tc ? '0 : baud_q + BW'(1);
                if (baud_tc) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + IW'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                baud_d = baud_tc ? '0 : baud_q + BW'(1);
                if (baud_tc) begin
                    if (!empty_q) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        baud_d  = '0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the next state so o_tx stays aligned with state_q.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
        ovf_d   = i_wr && full_q;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_busy     = (state_q != IDLE);
    assign o_overflow = ovf_q;
    assign o_tx       = tx_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- 8N1 UART transmitter with an integrated baud counter and a small transmit FIFO.
- It is the transmit side of the UART link. `uart_alu_top` uses it to serialise result bytes onto `o_tx` after operands arrive on `i_rx`.
- The FIFO decouples the producer from line timing, so several bytes can be queued and sent back-to-back with no idle gap.

Parameters:
- CLKS_PER_BIT, 2604, clocks per UART bit (50 MHz / 19200 baud); legal range ≥ 2.
- DEPTH, 4, number of FIFO entries; must be a power of 2 and ≥ 2.
- DATA_BITS, 8, payload bits per frame; fixed at 8 in this revision.

Ports:
- i_clk  in  1  system clock, rising-edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_data  in  8  byte to queue.
- i_wr  in  1  push strobe, sampled on the rising edge of i_clk.
- o_full  out  1  FIFO holds DEPTH entries.
- o_empty  out  1  FIFO holds 0 entries.
- o_busy  out  1  a frame is being shifted (state ≠ IDLE).
- o_overflow  out  1  one-cycle pulse when a push is dropped.
- o_tx  out  1  serial line, idle high, registered.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - o_tx=1, o_busy=0, o_empty=1, o_full=0, o_overflow=0.
  - FIFO pointers, count, bit counter and baud counter all cleared; FSM=IDLE.
- Reset mid-frame: o_tx returns to 1 immediately (asynchronous), and all queued bytes are discarded.
- FIFO:
  - Push occurs when i_wr=1 and o_full=0.
  - i_wr=1 while o_full=1: byte dropped, contents unchanged, o_overflow=1 for exactly that cycle. This applies even if the FSM pops in the same cycle.
  - Simultaneous push and pop: count is unchanged.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - o_full and o_empty are registered from the count and valid in the cycle after the edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If FIFO not empty on an edge: pop the head into the shift register, clear the baud counter, go to START.
  - START: o_tx=0 for CLKS_PER_BIT clocks, then go to DATA with bit index 0.
  - DATA: o_tx=shift[0] (LSB first) for CLKS_PER_BIT clocks, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT clocks. Then:
    - FIFO not empty: pop and go directly to START (no idle cycle).
    - otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, reloads at terminal count, width clog2(CLKS_PER_BIT).
- Latency: i_wr high at edge N with the FIFO empty and FSM IDLE gives o_tx=0 starting after edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT clocks from start-bit falling edge to the end of the stop bit.
- A byte is popped only at frame start. A push during a frame never alters the frame in flight.
- o_busy=1 in START, DATA and STOP; 0 in IDLE.

Test Plan:
- Reset, then hold idle 50 cycles -> o_tx=1, o_empty=1, o_busy=0, o_overflow never asserted.
- CLKS_PER_BIT=16; push 0x20 (ADD) at edge N:
  - o_tx falls after edge N+1.
  - Bit-centre samples read 0, then 0,0,0,0,0,1,0,0, then stop=1.
  - o_busy high for 160 cycles, then o_empty=1.
- Push 0x55, 0xA3, 0xFF on consecutive cycles:
  - Three frames are back-to-back, 480 cycles total at CLKS_PER_BIT=16.
  - Each stop bit is exactly 16 cycles, with no extra idle cycle.
  - Decoded bytes are 0x55, 0xA3, 0xFF in order.
- DEPTH=4; push 6 bytes on 6 consecutive cycles while idle:
  - The first byte is popped into the shifter, so 5 are accepted.
  - o_full asserts; o_overflow pulses exactly once, on the 6th push.
  - The serial output is bytes 1–5 in order.
- Assert i_reset_n=0 during DATA of 0x0F with 2 bytes still queued:
  - o_tx=1 the same cycle; o_busy=0; o_empty=1.
  - After release, no frame is sent until a new push.
- Pointer wrap: push and drain 10 bytes (0x00..0x09) one at a time with DEPTH=4 -> all 10 decoded correctly; o_empty=1 at the end.
